// File: rtl/mod_n_updown_counter.sv
// ============================================================================
// Module  : mod_n_updown_counter
// Brief   : Modulo-N up/down/load counter, wrap or saturate, cascadable co.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             cp,
  input  logic             rd,
  input  logic             clr,
  input  logic             cen,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ovf
);

  localparam logic [1:0] c_mode_hold = 2'b00;
  localparam logic [1:0] c_mode_up   = 2'b01;
  localparam logic [1:0] c_mode_down = 2'b10;
  localparam logic [1:0] c_mode_load = 2'b11;

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == c_max);
  assign at_zero = (count_q == c_zero);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = c_zero;
      ovf_d   = 1'b0;
    end else begin
      unique case (mode)
        c_mode_load: count_d = (d > c_max) ? c_max : d;
        c_mode_up: begin
          if (cen) begin
            if (!at_max) begin
              count_d = count_q + c_one;
            end else begin
              // Limit hit: flag is set whether we wrap or stick.
              ovf_d = 1'b1;
              if (!sat) count_d = c_zero;
            end
          end
        end
        c_mode_down: begin
          if (cen) begin
            if (!at_zero) begin
              count_d = count_q - c_one;
            end else begin
              ovf_d = 1'b1;
              if (!sat) count_d = c_max;
            end
          end
        end
        c_mode_hold: ;
        default: ;
      endcase
    end
  end

  // All state changes on the falling edge of cp.
  always_ff @(negedge cp or negedge rd) begin
    if (!rd) begin
      count_q <= c_zero;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Terminal-count look-ahead; feeds the next stage's cen on the same clock.
  assign co  = rd & cen & (((mode == c_mode_up) & at_max) | ((mode == c_mode_down) & at_zero));
  assign q   = count_q;
  assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
// ============================================================================
// Module  : tb_mod_n_updown_counter
// Brief   : Directed self-checking bench for mod_n_updown_counter (MODULUS=10).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mod_n_updown_counter;

  logic       cp;
  logic       rd;
  logic       clr;
  logic       cen;
  logic [1:0] mode;
  logic       sat;
  logic [3:0] d;
  logic [3:0] q;
  logic       co;
  logic       ovf;

  logic       c_clr;
  logic [1:0] c_mode;
  logic       c_sat;
  logic       lo_cen;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_ovf, hi_ovf;

  int checks;
  int failures;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .cp(cp), .rd(rd), .clr(clr), .cen(cen), .mode(mode), .sat(sat), .d(d),
    .q(q), .co(co), .ovf(ovf)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .cp(cp), .rd(rd), .clr(c_clr), .cen(lo_cen), .mode(c_mode), .sat(c_sat), .d(4'd0),
    .q(lo_q), .co(lo_co), .ovf(lo_ovf)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .cp(cp), .rd(rd), .clr(c_clr), .cen(lo_co), .mode(c_mode), .sat(c_sat), .d(4'd0),
    .q(hi_q), .co(hi_co), .ovf(hi_ovf)
  );

  initial cp = 1'b1;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one active (falling) edge and settle just after it.
  task automatic step();
    @(negedge cp);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rd = 1'b0; clr = 1'b0; cen = 1'b1; mode = 2'b01; sat = 1'b0; d = 4'd0;
    c_clr = 1'b1; c_mode = 2'b00; c_sat = 1'b0; lo_cen = 1'b1;

    // Reset state
    step();
    chk("rst_q", q, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_co", co, 0);
    rd = 1'b1;

    // 1: count to 7, async reset between edges, co gated by rd
    for (int i = 1; i <= 7; i++) step();
    chk("pre_rst_q", q, 7);
    #2 rd = 1'b0; mode = 2'b10;
    #1;
    chk("async_q", q, 0);
    chk("async_ovf", ovf, 0);
    chk("async_co_gated", co, 0);
    mode = 2'b01;
    #1 rd = 1'b1;
    step();
    chk("post_rst_q", q, 1);

    // 2: up wrap
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_q", q, 0);
    for (int i = 1; i <= 9; i++) begin
      chk("up_co_pre", co, 0);
      step();
      chk("up_q", q, i);
      chk("up_ovf", ovf, 0);
    end
    chk("up_co_at9", co, 1);
    step();
    chk("wrap_q", q, 0);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_co", co, 0);
    step(); step(); step();
    chk("sticky_q", q, 3);
    chk("sticky_ovf", ovf, 1);

    // 3: down saturate, then wrap
    clr = 1'b1; step(); clr = 1'b0;
    sat = 1'b1; mode = 2'b10; #1;
    chk("dn_co_at0", co, 1);
    step();
    chk("dn_sat_q", q, 0);
    chk("dn_sat_ovf", ovf, 1);
    sat = 1'b0;
    step();
    chk("dn_wrap_q", q, 9);
    chk("dn_co_at9", co, 0);

    // 4: load clamp, cen independence, hold
    cen = 1'b0; mode = 2'b11; d = 4'd12;
    step();
    chk("load_clamp", q, 9);
    d = 4'd5;
    step();
    chk("load_5", q, 5);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_q", q, 5);
    end
    mode = 2'b01;
    step();
    chk("cen0_q", q, 5);
    chk("cen0_co", co, 0);

    // 5: priority of clr
    chk("pri_ovf_pre", ovf, 1);
    clr = 1'b1; mode = 2'b11; d = 4'd3;
    step();
    chk("pri_load_q", q, 0);
    chk("pri_load_ovf", ovf, 0);
    clr = 1'b0; d = 4'd9;
    step();
    chk("load_9", q, 9);
    mode = 2'b01; cen = 1'b1; clr = 1'b1; #1;
    chk("pri_co_clr", co, 1);
    step();
    chk("pri_lim_q", q, 0);
    chk("pri_lim_ovf", ovf, 0);
    clr = 1'b0;

    // 6: two-stage cascade
    c_clr = 1'b0; c_mode = 2'b01;
    for (int n = 1; n <= 100; n++) begin
      chk("casc_hi_co", hi_co, ((n - 1) == 99) ? 1 : 0);
      step();
      chk("casc_val", hi_q * 10 + lo_q, n % 100);
    end
    chk("casc_hi_ovf", hi_ovf, 1);
    c_mode = 2'b10; #1;
    chk("casc_dn_hi_co", hi_co, 1);
    step();
    chk("casc_dn_99", hi_q * 10 + lo_q, 99);
    step();
    chk("casc_dn_98", hi_q * 10 + lo_q, 98);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
